// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, redirect input
// from execute, and the instruction handshake toward decode.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    // Instruction memory
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;

    // Redirect from execute
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;

    // Decode-side handshake
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic [6:0]        inst_opcode;
    logic              fetch_fault;

    // The fetch unit drives requests and instructions.
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_target,
        output inst_valid, inst_data, inst_pc, inst_opcode, fetch_fault,
        input  inst_ready
    );

    // Memory, execute and decode together form the environment side.
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_target,
        input  inst_valid, inst_data, inst_pc, inst_opcode, fetch_fault,
        output inst_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, keeps at most one instruction-memory
// read outstanding, and holds the fetched word in a one-entry buffer for
// decode. Redirects from execute flush the buffer and discard any in-flight
// response; a misaligned redirect target halts fetch until reset.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic               clk,
    input logic               reset,
    instr_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_REQ,   // request phase
        S_WAIT,  // awaiting the response to our request
        S_DROP,  // awaiting a response that will be discarded
        S_HALT   // misaligned redirect seen; idle until reset
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic [31:0]       inst_data_q, inst_data_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              fault_q, fault_d;

    logic req_valid;
    logic req_fire;
    logic consume;
    logic redirect_ok;
    logic redirect_bad;

    // Request only when the buffer will be free by the time the response
    // lands, so a response can always be written without back-pressure.
    always_comb begin
        req_valid    = (state_q == S_REQ) && (!inst_valid_q || bus.inst_ready) && !reset;
        req_fire     = req_valid && bus.imem_req_ready;
        consume      = inst_valid_q && bus.inst_ready;
        redirect_ok  = bus.redirect_valid && (state_q != S_HALT) &&
                       (bus.redirect_target[1:0] == 2'b00);
        redirect_bad = bus.redirect_valid && (state_q != S_HALT) &&
                       (bus.redirect_target[1:0] != 2'b00);
    end

    // Next-state logic: normal fetch flow first, then redirect/fault override.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q;
        inst_data_d  = inst_data_q;
        inst_pc_d    = inst_pc_q;
        fault_d      = fault_q;

        if (consume) begin
            inst_valid_d = 1'b0;
        end

        unique case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    inst_data_d  = bus.imem_rsp_data;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    pc_d         = pc_q + ADDR_W'(4);
                    state_d      = S_REQ;
                end
            end
            S_DROP: begin
                if (bus.imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
        endcase

        if (redirect_bad) begin
            // Any outstanding response is simply never looked at again.
            inst_data_d  = inst_data_q;
            inst_pc_d    = inst_pc_q;
            pc_d         = pc_q;
            inst_valid_d = 1'b0;
            fault_d      = 1'b1;
            state_d      = S_HALT;
        end else if (redirect_ok) begin
            inst_data_d  = inst_data_q;
            inst_pc_d    = inst_pc_q;
            pc_d         = bus.redirect_target;
            inst_valid_d = 1'b0;
            unique case (state_q)
                S_REQ:   state_d = req_fire ? S_DROP : S_REQ;
                S_WAIT:  state_d = bus.imem_rsp_valid ? S_REQ : S_DROP;
                // A response landing this cycle is the one being dropped, so
                // nothing is outstanding afterwards.
                S_DROP:  state_d = bus.imem_rsp_valid ? S_REQ : S_DROP;
                default: state_d = state_q;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_data_q  <= '0;
            inst_pc_q    <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
            inst_data_q  <= inst_data_d;
            inst_pc_q    <= inst_pc_d;
            fault_q      <= fault_d;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst_data      = inst_data_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.inst_opcode    = inst_data_q[6:0];
    assign bus.fetch_fault    = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, back-pressure,
// redirects against in-flight responses, misaligned fault, PC wrap and reset.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   auto_mem;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(32)) bus ();

    instr_fetch_unit #(
        .ADDR_W  (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Instruction memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   mem_word = 32'h0000_0033;
            32'h4:   mem_word = 32'h0000_3003;
            32'h8:   mem_word = 32'h0000_3023;
            32'hC:   mem_word = 32'h0000_0063;
            default: mem_word = {a[31:7], 7'h13};
        endcase
    endfunction

    // One clock cycle. With auto_mem set, a request accepted at this edge is
    // answered during the following cycle (1-cycle memory).
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        #1;
        acc = bus.imem_req_valid && bus.imem_req_ready;
        a   = bus.imem_req_addr;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        if (auto_mem) begin
            bus.imem_rsp_valid = acc;
            bus.imem_rsp_data  = acc ? mem_word(a) : 32'h0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        tick();
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        check("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic wait_inst(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (bus.inst_valid) seen = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] exp_op [4];
        bit          seen;
        int          got;
        int          hi;

        exp_op = '{32'h33, 32'h03, 32'h23, 32'h63};

        reset               = 1'b1;
        auto_mem            = 1'b1;
        bus.imem_req_ready  = 1'b1;
        bus.imem_rsp_valid  = 1'b0;
        bus.imem_rsp_data   = 32'h0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        bus.inst_ready      = 1'b1;

        // ---- reset state and sequential fetch ----
        do_reset();
        check("rst_fault", 32'(bus.fetch_fault), 32'h0);
        check("rst_addr", bus.imem_req_addr, 32'h0);
        check("rst_inst_data", bus.inst_data, 32'h0);
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            tick();
            if (bus.inst_valid) begin
                if (got == 0) check("seq_latency", 32'(c), 32'h1);
                check("seq_pc", bus.inst_pc, 32'(got * 4));
                check("seq_opcode", 32'(bus.inst_opcode), exp_op[got]);
                got++;
            end
        end
        check("seq_count", 32'(got), 32'h4);

        // ---- back-pressure ----
        bus.inst_ready = 1'b0;
        do_reset();
        wait_inst(4, seen);
        check("bp_seen", 32'(seen), 32'h1);
        for (int i = 0; i < 5; i++) begin
            check("bp_req_valid", 32'(bus.imem_req_valid), 32'h0);
            check("bp_data", bus.inst_data, 32'h0000_0033);
            tick();
        end
        check("bp_inst_valid", 32'(bus.inst_valid), 32'h1);
        check("bp_pc", bus.inst_pc, 32'h0);
        bus.inst_ready = 1'b1;
        #1;
        check("bp_release_req", 32'(bus.imem_req_valid), 32'h1);
        check("bp_release_addr", bus.imem_req_addr, 32'h4);
        tick();
        check("bp_consumed", 32'(bus.inst_valid), 32'h0);

        // ---- redirect during S_WAIT, response one cycle later ----
        auto_mem = 1'b0;
        do_reset();
        tick();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0100;
        tick();
        check("rdw_drop_req", 32'(bus.imem_req_valid), 32'h0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        bus.imem_rsp_valid = 1'b0;
        #1;
        check("rdw_no_stale", 32'(bus.inst_valid), 32'h0);
        check("rdw_req_valid", 32'(bus.imem_req_valid), 32'h1);
        check("rdw_req_addr", bus.imem_req_addr, 32'h0000_0100);
        auto_mem = 1'b1;
        wait_inst(4, seen);
        check("rdw_seen", 32'(seen), 32'h1);
        check("rdw_pc", bus.inst_pc, 32'h0000_0100);
        check("rdw_data", bus.inst_data, 32'h0000_0113);

        // ---- redirect coincident with response ----
        auto_mem = 1'b0;
        do_reset();
        tick();
        bus.imem_rsp_valid  = 1'b1;
        bus.imem_rsp_data   = 32'h1234_5678;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0200;
        tick();
        bus.imem_rsp_valid = 1'b0;
        #1;
        check("rdr_inst_valid", 32'(bus.inst_valid), 32'h0);
        check("rdr_req_valid", 32'(bus.imem_req_valid), 32'h1);
        check("rdr_req_addr", bus.imem_req_addr, 32'h0000_0200);

        // ---- misaligned redirect ----
        auto_mem = 1'b1;
        do_reset();
        tick();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0102;
        tick();
        check("mis_fault", 32'(bus.fetch_fault), 32'h1);
        check("mis_inst_valid", 32'(bus.inst_valid), 32'h0);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.imem_req_valid || bus.inst_valid) hi++;
            tick();
        end
        check("mis_halted", 32'(hi), 32'h0);
        check("mis_fault_sticky", 32'(bus.fetch_fault), 32'h1);
        do_reset();
        check("mis_fault_clear", 32'(bus.fetch_fault), 32'h0);
        check("mis_req_valid", 32'(bus.imem_req_valid), 32'h1);
        check("mis_req_addr", bus.imem_req_addr, 32'h0);

        // ---- PC wrap (redirect while the request is accepted) ----
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'hFFFF_FFFC;
        tick();
        check("wrap_drop_req", 32'(bus.imem_req_valid), 32'h0);
        tick();
        check("wrap_no_stale", 32'(bus.inst_valid), 32'h0);
        check("wrap_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
        wait_inst(4, seen);
        check("wrap_seen", 32'(seen), 32'h1);
        check("wrap_pc", bus.inst_pc, 32'hFFFF_FFFC);
        check("wrap_data", bus.inst_data, 32'hFFFF_FF93);
        check("wrap_next_addr", bus.imem_req_addr, 32'h0);
        check("wrap_no_fault", 32'(bus.fetch_fault), 32'h0);

        // ---- reset while in S_WAIT, stale response during reset ----
        tick();
        auto_mem           = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        reset              = 1'b1;
        #1;
        check("mrst_req_low", 32'(bus.imem_req_valid), 32'h0);
        tick();
        check("mrst_inst_valid", 32'(bus.inst_valid), 32'h0);
        check("mrst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0000_0BAD;
        tick();
        bus.imem_rsp_valid = 1'b0;
        reset              = 1'b0;
        #1;
        check("mrst_post_req", 32'(bus.imem_req_valid), 32'h1);
        check("mrst_post_addr", bus.imem_req_addr, 32'h0);
        check("mrst_post_valid", 32'(bus.inst_valid), 32'h0);
        auto_mem = 1'b1;
        wait_inst(4, seen);
        check("mrst_seen", 32'(seen), 32'h1);
        check("mrst_pc", bus.inst_pc, 32'h0);
        check("mrst_data", bus.inst_data, 32'h0000_0033);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
